// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, MIPS funct values and mul/div types
// for the EX-stage ALU control unit.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_PASS = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // Encoding matches funct[1:0] of the mul/div group
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, sign fix-up in FIX.
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             idle,
    output logic             wr,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_q, a_d;
    md_op_t           op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sgn_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum, shifted, diff;
    logic             ge, is_mul, neg;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sgn_in  = (op == MULT) || (op == DIV);
        mag_a   = (sgn_in && a[WIDTH-1]) ? -a : a;
        mag_b   = (sgn_in && b[WIDTH-1]) ? -b : b;
        is_mul  = (op_q == MULT) || (op_q == MULTU);
        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {acc_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = ~diff[WIDTH];
        neg     = sa_q ^ sb_q;
        prod    = {acc_q, lo_q};

        // Divide by zero overrides the signed fix-up entirely
        res_hi = '0;
        res_lo = '0;
        if (is_mul) begin
            {res_hi, res_lo} = neg ? -prod : prod;
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_lo = neg ? -lo_q : lo_q;
            res_hi = sa_q ? -acc_q : acc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        a_d     = a_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        wr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d = ITER;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = mag_a;
                    b_d     = mag_b;
                    a_d     = a;
                    op_d    = op;
                    sa_d    = sgn_in && a[WIDTH-1];
                    sb_d    = sgn_in && b[WIDTH-1];
                end
            end
            ITER: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_mul) begin
                        {acc_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
                    end else begin
                        acc_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        lo_d  = {lo_q[WIDTH-2:0], ge};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                wr      = !flush;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            a_q     <= '0;
            op_q    <= MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            a_q     <= a_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign idle = (state_q == IDLE);

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control: ALUOp/funct decode, illegal detection,
// HI/LO registers and stall toward pipeline control.
module alu_ctrl_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal,
    output logic [1:0]        hilo_sel,
    output logic [WIDTH-1:0]  hilo_data,
    output logic              stall,
    output logic              busy,
    output logic              md_done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    logic [3:0]       code;
    logic             ill, is_md, is_mfx;
    logic             start, idle, wr;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    always_comb begin
        code     = ALU_ILL;
        ill      = 1'b1;
        hilo_sel = 2'b00;
        is_md    = 1'b0;
        is_mfx   = 1'b0;
        unique case (alu_op)
            2'b00: begin code = ALU_ADD; ill = 1'b0; end
            2'b01: begin code = ALU_SUB; ill = 1'b0; end
            2'b10: begin
                case (funct)
                    F_ADD: begin code = ALU_ADD; ill = 1'b0; end
                    F_SUB: begin code = ALU_SUB; ill = 1'b0; end
                    F_AND: begin code = ALU_AND; ill = 1'b0; end
                    F_OR:  begin code = ALU_OR;  ill = 1'b0; end
                    F_SLT: begin code = ALU_SLT; ill = 1'b0; end
                    F_NOR: begin code = ALU_NOR; ill = 1'b0; end
                    F_MFHI: begin
                        code     = ALU_PASS;
                        ill      = 1'b0;
                        hilo_sel = 2'b01;
                        is_mfx   = 1'b1;
                    end
                    F_MFLO: begin
                        code     = ALU_PASS;
                        ill      = 1'b0;
                        hilo_sel = 2'b10;
                        is_mfx   = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        code  = ALU_PASS;
                        ill   = 1'b0;
                        is_md = 1'b1;
                    end
                    default: ;
                endcase
            end
            2'b11: ;
            default: ;
        endcase
    end

    assign alu_control = CTRL_W'(code);
    assign illegal     = in_valid && ill;
    // Only ops that touch HI/LO wait for the engine
    assign stall = in_valid && (busy || !idle) && (is_md || is_mfx);
    assign start = in_valid && is_md && !stall;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (md_op_t'(funct[1:0])),
        .a      (src_a),
        .b      (src_b),
        .busy   (busy),
        .done   (md_done),
        .idle   (idle),
        .wr     (wr),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        hi_d = wr ? res_hi : hi_q;
        lo_d = wr ? res_lo : lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        unique case (hilo_sel)
            2'b01:   hilo_data = hi_q;
            2'b10:   hilo_data = lo_q;
            default: hilo_data = '0;
        endcase
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

Second-generation ALU control unit for the MIPS datapath. It keeps the ALUOp/funct decode and adds NOR and illegal-opcode detection. It also adds an iterative multiply/divide engine with HI/LO registers and a stall handshake toward the pipeline control. It sits between the main control/ID stage and the EX-stage ALU and result mux.

## Interface
- WIDTH, 32: operand and HI/LO width; must be even and ≥ 4.
- CTRL_W, 4: ALU control code width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved.
- funct  in  6  R-type function field.
- in_valid  in  1  an instruction is presented this cycle.
- flush  in  1  abort any multiply/divide in flight.
- src_a, src_b  in  WIDTH  rs and rt operands.
- alu_control  out  CTRL_W  ALU operation code (combinational).
- illegal  out  1  unknown alu_op/funct combination (combinational).
- hilo_sel  out  2  00 none, 01 mfhi, 10 mflo (combinational).
- hilo_data  out  WIDTH  HI or LO selected by hilo_sel; 0 when hilo_sel is 00.
- stall  out  1  hold the instruction in EX (combinational).
- busy  out  1  engine running (registered).
- md_done  out  1  one-cycle pulse when HI/LO have been written.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Decode for alu_op 00 and 01:
  - 00 → 0010.
  - 01 → 0110.
- Decode for alu_op 10, by funct:
  - 100000 → 0010 (add).
  - 100010 → 0110 (sub).
  - 100100 → 0000 (and).
  - 100101 → 0001 (or).
  - 101010 → 0111 (slt).
  - 100111 → 1100 (nor).
  - 010000 → 1000, hilo_sel=01 (mfhi).
  - 010010 → 1000, hilo_sel=10 (mflo).
  - 011000/011001/011010/011011 → 1000, start mult/multu/div/divu.
- Any other funct, or alu_op 11 → alu_control=1111, illegal=1. No latching of the previous value.
- Decode outputs depend only on alu_op/funct and are independent of in_valid. illegal and stall are gated by in_valid.
- FSM states:
  - IDLE: accept when in_valid && muldiv funct && !flush && !stall; go to ITER.
  - ITER: WIDTH iterations, one per cycle. Multiply uses shift-add on magnitudes. Divide uses restoring divide on magnitudes.
  - FIX: apply signs (signed ops); write hi/lo; go to IDLE; md_done=1 in the next cycle.
- Signed rules:
  - Product sign is sign_a^sign_b.
  - Quotient sign is sign_a^sign_b.
  - Remainder takes the sign of the dividend.
- Multiply result: {hi,lo} = 2·WIDTH-bit product.
- Divide result: lo = quotient, hi = remainder.
- Divide by zero (either signedness): lo = all ones, hi = src_a. Normal latency.
- Signed overflow (most-negative ÷ −1): lo = most-negative, hi = 0.
- stall=1 when in_valid and (busy or FSM≠IDLE) and the instruction is muldiv, mfhi or mflo. Other ops pass with stall=0 while the engine runs.
- flush: if FSM≠IDLE, return to IDLE next cycle with hi/lo unchanged and no md_done. A flush in the same cycle as a would-be accept blocks the accept.
- Reset mid-operation: FSM → IDLE; hi, lo, busy and md_done clear asynchronously.

## Timing
- Reset values: hi=0, lo=0, busy=0, md_done=0, FSM=IDLE.
- Combinational outputs follow their inputs with no reset dependence.
- Accept edge is E0.
- busy=1 from the cycle after E0 for exactly WIDTH+1 cycles (WIDTH in ITER, 1 in FIX).
- hi/lo update at the edge ending FIX (E0+WIDTH+1).
- md_done and busy=0 are visible in the cycle following that edge.
- mfhi/mflo issued in the cycle md_done is high reads the new values without stall.
- Back-to-back: a new muldiv is accepted no earlier than the cycle md_done is high, so throughput is one op per WIDTH+2 cycles.
- Operands are sampled only at E0; later changes on src_a/src_b are ignored.

## Structure
- Package alu_ctrl_pkg holds:
  - ALU code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NOR, ALU_PASS, ALU_ILL).
  - funct constants.
  - md_op_t enum (MULT, MULTU, DIV, DIVU).
  - md_state_t enum (IDLE, ITER, FIX).
- Sub-module muldiv_iter (parametrised by WIDTH) contains the FSM, the iteration counter ($clog2(WIDTH+1) bits) and the shift/accumulate datapath.
- The top level holds the combinational decode, stall logic, HI/LO registers and the hilo_data mux.

## Test plan
- Decode sweep, all 4 alu_op × 64 funct: each listed code matches the Operation table; all others give 1111 with illegal=1 when in_valid=1.
- mult with src_a=0xFFFFFFFD (−3) and src_b=7: hi=0xFFFFFFFF and lo=0xFFFFFFEB at E0+33; md_done pulses once; busy high exactly 33 cycles.
- divu 100/7 → lo=14, hi=2.
- div with src_a=0xFFFFFFF9 (−7) and src_b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div by zero: src_a=0x12345678, src_b=0 → lo=0xFFFFFFFF, hi=0x12345678.
- div 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
- While busy:
  - mflo with in_valid → stall=1.
  - add → stall=0 with alu_control=0010.
  - flush at cycle E0+10 → IDLE next cycle, hi/lo keep their old values, no md_done.
- Reset mid-operation: assert rst_n=0 at E0+5 → hi=lo=0 and busy=0 immediately. A new multu 0xFFFFFFFF×0xFFFFFFFF then yields hi=0xFFFFFFFE, lo=0x00000001.
